// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the sdram command arbiter.
package sdram_arb_pkg;

  localparam int ROW_W_DEF  = 14;
  localparam int BANK_W_DEF = 2;
  localparam int DATA_W     = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_END = 2'd2
  } state_t;

  localparam logic OWN_WR = 1'b0;
  localparam logic OWN_RD = 1'b1;

endpackage

// File: rtl/sdram_arb_timer.sv
// WAIT_END watchdog: counts cycles while running, flags the last allowed cycle.
module sdram_arb_timer #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic i_clock_100,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge i_clock_100) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_run && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_run && (r_count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester sdram command arbiter (writer priority, reader anti-starvation).
// Optional WAIT_END watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ROW_W       = ROW_W_DEF,
  parameter int BANK_W      = BANK_W_DEF,
  parameter int STARVE_MAX  = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              i_clock_100,
  input  logic              i_reset,
  input  logic              i_wr_req,
  input  logic [BANK_W-1:0] i_wr_bank,
  input  logic [ROW_W-1:0]  i_wr_row,
  output logic              o_wr_grant,
  output logic              o_wr_done,
  input  logic              i_rd_req,
  input  logic [BANK_W-1:0] i_rd_bank,
  input  logic [ROW_W-1:0]  i_rd_row,
  output logic              o_rd_grant,
  output logic              o_rd_done,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_data_valid,
  output logic              o_sd_req_write,
  output logic              o_sd_req_read,
  output logic [BANK_W-1:0] o_sd_bank,
  output logic [ROW_W-1:0]  o_sd_row,
  input  logic              i_sd_data_out_valid,
  input  logic              i_sd_end_operation,
  input  logic [DATA_W-1:0] i_sd_data_out,
  output logic              o_busy,
  output logic              o_owner,
  output logic              o_timeout_err
);

  localparam int STV_W = $clog2(STARVE_MAX + 1);

  state_t             r_state, w_next_state;
  logic               w_start, w_finish, w_pick_rd, w_expired;
  logic [STV_W-1:0]   r_starve;
  logic               r_wr_grant, r_rd_grant, r_wr_done, r_rd_done;
  logic               r_busy, r_owner, r_rd_data_valid;
  logic [BANK_W-1:0]  r_sd_bank;
  logic [ROW_W-1:0]   r_sd_row;
  logic [DATA_W-1:0]  r_rd_data;

  // Reader only beats a pending writer once it has been passed over STARVE_MAX times.
  assign w_pick_rd = i_rd_req && (!i_wr_req || (r_starve == STV_W'(STARVE_MAX)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_wr_req || i_rd_req) begin
          w_next_state = ISSUE;
          w_start      = 1'b1;
        end
      end
      ISSUE:    w_next_state = WAIT_END;
      WAIT_END: begin
        if (i_sd_end_operation || w_expired) begin
          w_next_state = IDLE;
          w_finish     = 1'b1;
        end
      end
      default:  w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock_100) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_starve        <= '0;
      r_wr_grant      <= 1'b0;
      r_rd_grant      <= 1'b0;
      r_wr_done       <= 1'b0;
      r_rd_done       <= 1'b0;
      r_busy          <= 1'b0;
      r_owner         <= OWN_WR;
      r_sd_bank       <= '0;
      r_sd_row        <= '0;
      r_rd_data_valid <= 1'b0;
      r_rd_data       <= '0;
    end else begin
      r_state    <= w_next_state;
      r_busy     <= (w_next_state != IDLE);
      r_wr_grant <= w_start && !w_pick_rd;
      r_rd_grant <= w_start && w_pick_rd;
      r_wr_done  <= w_finish && (r_owner == OWN_WR);
      r_rd_done  <= w_finish && (r_owner == OWN_RD);
      if (w_start) begin
        r_owner   <= w_pick_rd ? OWN_RD : OWN_WR;
        r_sd_bank <= w_pick_rd ? i_rd_bank : i_wr_bank;
        r_sd_row  <= w_pick_rd ? i_rd_row : i_wr_row;
        if (w_pick_rd || !i_rd_req) begin
          r_starve <= '0;
        end else if (r_starve != STV_W'(STARVE_MAX)) begin
          r_starve <= r_starve + 1'b1;
        end
      end
      r_rd_data_valid <= (r_state != IDLE) && (r_owner == OWN_RD) && i_sd_data_out_valid;
      if ((r_state != IDLE) && (r_owner == OWN_RD) && i_sd_data_out_valid) begin
        r_rd_data <= i_sd_data_out;
      end
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  logic r_timeout_err;

  sdram_arb_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .i_clock_100 (i_clock_100),
    .i_reset     (i_reset),
    .i_clear     (r_state == ISSUE),
    .i_run       (r_state == WAIT_END),
    .o_expired   (w_expired)
  );

  // A coincident end_operation counts as a normal completion, not a timeout.
  always_ff @(posedge i_clock_100) begin
    if (i_reset) begin
      r_timeout_err <= 1'b0;
    end else if ((r_state == WAIT_END) && w_expired && !i_sd_end_operation) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  logic w_timeout_unused;

  assign w_expired        = 1'b0;
  assign w_timeout_unused = (TIMEOUT_CYC == 0);
  assign o_timeout_err    = 1'b0;
`endif

  assign o_wr_grant      = r_wr_grant;
  assign o_rd_grant      = r_rd_grant;
  assign o_sd_req_write  = r_wr_grant;
  assign o_sd_req_read   = r_rd_grant;
  assign o_wr_done       = r_wr_done;
  assign o_rd_done       = r_rd_done;
  assign o_busy          = r_busy;
  assign o_owner         = r_owner;
  assign o_sd_bank       = r_sd_bank;
  assign o_sd_row        = r_sd_row;
  assign o_rd_data_valid = r_rd_data_valid;
  assign o_rd_data       = r_rd_data;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_sdram_arbiter;

  localparam int STARVE_MAX = 8;
  localparam int TO_CYC     = 16;

  logic        clk = 1'b0;
  logic        reset, wr_req, rd_req, sd_dv, sd_end;
  logic [1:0]  wr_bank, rd_bank;
  logic [13:0] wr_row, rd_row;
  logic [15:0] sd_data;

  logic        wr_grant, wr_done, rd_grant, rd_done, rd_data_valid;
  logic        sd_req_write, sd_req_read, busy, owner, timeout_err;
  logic [1:0]  sd_bank;
  logic [13:0] sd_row;
  logic [15:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: arbiter seen as "free" or "serving one transaction".
  bit          m_free = 1'b1;
  int          m_starve = 0;
  int          m_since = 0;
  bit          m_owner = 1'b0;
  bit          m_terr = 1'b0;
  logic [1:0]  m_bank = '0;
  logic [13:0] m_row = '0;
  logic [15:0] m_data = '0;
  bit          e_wg, e_rg, e_wd, e_rd, e_rdv;

  sdram_arbiter #(
    .ROW_W(14), .BANK_W(2), .STARVE_MAX(STARVE_MAX), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .i_clock_100         (clk),
    .i_reset             (reset),
    .i_wr_req            (wr_req),
    .i_wr_bank           (wr_bank),
    .i_wr_row            (wr_row),
    .o_wr_grant          (wr_grant),
    .o_wr_done           (wr_done),
    .i_rd_req            (rd_req),
    .i_rd_bank           (rd_bank),
    .i_rd_row            (rd_row),
    .o_rd_grant          (rd_grant),
    .o_rd_done           (rd_done),
    .o_rd_data           (rd_data),
    .o_rd_data_valid     (rd_data_valid),
    .o_sd_req_write      (sd_req_write),
    .o_sd_req_read       (sd_req_read),
    .o_sd_bank           (sd_bank),
    .o_sd_row            (sd_row),
    .i_sd_data_out_valid (sd_dv),
    .i_sd_end_operation  (sd_end),
    .i_sd_data_out       (sd_data),
    .o_busy              (busy),
    .o_owner             (owner),
    .o_timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    bit rd_win, timed_out;
    e_wg = 0; e_rg = 0; e_wd = 0; e_rd = 0; e_rdv = 0;
    if (reset) begin
      m_free = 1; m_starve = 0; m_owner = 0; m_terr = 0;
    end else if (m_free) begin
      if (wr_req || rd_req) begin
        rd_win = rd_req && (!wr_req || m_starve == STARVE_MAX);
        if (rd_win || !rd_req) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        m_owner = rd_win;
        m_bank  = rd_win ? rd_bank : wr_bank;
        m_row   = rd_win ? rd_row : wr_row;
        e_wg    = !rd_win;
        e_rg    = rd_win;
        m_free  = 0;
        m_since = 0;
      end
    end else begin
      m_since++;
      if (m_owner && sd_dv) begin
        e_rdv  = 1;
        m_data = sd_data;
      end
      timed_out = 0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      timed_out = (m_since == TO_CYC + 1) && !sd_end;
`endif
      if (m_since >= 2 && (sd_end || timed_out)) begin
        e_wd   = !m_owner;
        e_rd   = m_owner;
        m_free = 1;
        if (timed_out) m_terr = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("wr_grant", wr_grant, e_wg);
    check("rd_grant", rd_grant, e_rg);
    check("sd_req_write", sd_req_write, e_wg);
    check("sd_req_read", sd_req_read, e_rg);
    check("wr_done", wr_done, e_wd);
    check("rd_done", rd_done, e_rd);
    check("busy", busy, !m_free);
    check("rd_data_valid", rd_data_valid, e_rdv);
    check("timeout_err", timeout_err, m_terr);
    if (!m_free) begin
      check("owner", owner, m_owner);
      check("sd_bank", sd_bank, m_bank);
      check("sd_row", sd_row, m_row);
    end
    if (e_rdv) check("rd_data", rd_data, m_data);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic pulse_reset();
    reset = 1; step(); reset = 0;
  endtask

  int order[$];
  int k, guard, waited;

  initial begin
    reset = 1; wr_req = 0; rd_req = 0; sd_dv = 0; sd_end = 0;
    wr_bank = '0; rd_bank = '0; wr_row = '0; rd_row = '0; sd_data = '0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_grant", wr_grant | rd_grant, 0);
    check("rst_bank_row", {sd_bank, sd_row}, 0);
    reset = 0; step();

    // Writer transaction with fixed latency
    wr_req = 1; wr_bank = 2'd2; wr_row = 14'h01A5; step();
    check("t1_grant", wr_grant, 1);
    check("t1_sdw", sd_req_write, 1);
    check("t1_bank", sd_bank, 2);
    check("t1_row", sd_row, 14'h01A5);
    wr_req = 0;
    repeat (11) step();
    sd_end = 1; step(); sd_end = 0;
    check("t1_done", wr_done, 1);

    // Simultaneous requests: writer first, reader on the next free cycle
    wr_req = 1; rd_req = 1; wr_bank = 1; rd_bank = 3; rd_row = 14'h2222; step();
    check("t2_wgrant", wr_grant, 1);
    check("t2_rgrant_early", rd_grant, 0);
    wr_req = 0; sd_end = 1; step();
    sd_end = 1; step(); sd_end = 0;
    check("t2_wdone", wr_done, 1);
    step();
    check("t2_rgrant", rd_grant, 1);
    check("t2_rbank", sd_bank, 3);
    rd_req = 0; step();
    sd_end = 1; step(); sd_end = 0;
    check("t2_rdone", rd_done, 1);

    // Read data routed only during reader ownership
    rd_req = 1; step(); rd_req = 0; step();
    sd_dv = 1; sd_data = 16'hBEEF; step(); sd_dv = 0;
    check("t4_rdv", rd_data_valid, 1);
    check("t4_data", rd_data, 16'hBEEF);
    sd_end = 1; step(); sd_end = 0;
    wr_req = 1; step(); wr_req = 0; step();
    sd_dv = 1; step(); sd_dv = 0;
    check("t4_wr_rdv", rd_data_valid, 0);
    sd_end = 1; step(); sd_end = 0;

    // Reset while waiting for end_operation
    wr_req = 1; step(); wr_req = 0; step(); step();
    pulse_reset();
    check("t5_busy", busy, 0);
    check("t5_outs", {wr_grant, wr_done, rd_grant, rd_done, owner, sd_bank, sd_row}, 0);
    sd_end = 1; step(); sd_end = 0;
    check("t5_no_done", wr_done | rd_done, 0);

    // Starvation: both held, end 4 cycles after each issue
    wr_req = 1; rd_req = 1; k = 100; guard = 0;
    while (order.size() < 18 && guard < 500) begin
      sd_end = (k == 4);
      step();
      guard++;
      if (wr_grant) begin order.push_back(0); k = 0; end
      else if (rd_grant) begin order.push_back(1); k = 0; end
      else k++;
    end
    wr_req = 0; rd_req = 0; sd_end = 0;
    check("t3_grants", order.size(), 18);
    foreach (order[i]) check("t3_order", order[i], (i % 9 == 8) ? 1 : 0);
    pulse_reset();

    // Watchdog
    wr_req = 1; step(); wr_req = 0;
`ifdef SDRAM_ARB_TIMEOUT_EN
    waited = 0;
    while (!wr_done && waited < 100) begin step(); waited++; end
    check("t6_latency", waited, 17);
    check("t6_terr", timeout_err, 1);
    repeat (3) step();
    check("t6_sticky", timeout_err, 1);
    pulse_reset();
    check("t6_terr_clr", timeout_err, 0);
`else
    repeat (40) step();
    check("t6_busy", busy, 1);
    check("t6_terr", timeout_err, 0);
    pulse_reset();
`endif

    // Randomized traffic, including withdrawals, stray ends and resets
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (!wr_req) begin
        if ($urandom_range(0, 3) == 0) begin
          wr_req = 1; wr_bank = 2'($urandom); wr_row = 14'($urandom);
        end
      end else if (wr_grant || $urandom_range(0, 39) == 0) begin
        wr_req = 0;
      end
      if (!rd_req) begin
        if ($urandom_range(0, 3) == 0) begin
          rd_req = 1; rd_bank = 2'($urandom); rd_row = 14'($urandom);
        end
      end else if (rd_grant || $urandom_range(0, 39) == 0) begin
        rd_req = 0;
      end
      sd_end  = ($urandom_range(0, 5) == 0);
      sd_dv   = ($urandom_range(0, 2) == 0);
      sd_data = 16'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
